// File: rtl/entrada_pkg.sv
// Shared definitions for the two-digit keypad entry path: FSM state encoding,
// digit/value limits and the tens*10+units arithmetic helper.
package entrada_pkg;

  typedef enum logic {
    DECENA = 1'b0,
    UNIDAD = 1'b1
  } estado_e;

  localparam logic [3:0] DECENA_MAX = 4'd6;
  localparam logic [3:0] DIGITO_MAX = 4'd9;
  localparam logic [6:0] NUMERO_MAX = 7'd63;

  // tens*10 + units built from shifts so no multiplier is needed; 7 bits
  // holds the worst case (6*10 + 15 = 75) so the range check is exact.
  function automatic logic [6:0] calc_valor(input logic [2:0] decena,
                                            input logic [3:0] unidad);
    logic [6:0] d7;
    d7 = {4'b0000, decena};
    return (d7 << 3) + (d7 << 1) + {3'b000, unidad};
  endfunction

endpackage

// File: rtl/capturador_numero_2digitos_detector_flanco.sv
// Registered rising-edge detector: one-cycle pulse on the first cycle a level
// input is seen high. The previous-level register resets to 0, so a level
// already high when reset releases yields a pulse on the first cycle.
module detector_flanco (
  input  logic Reloj,
  input  logic Reset_n,
  input  logic Tecla,
  output logic Pulso
);

  logic previo_q;

  // Remember last cycle's level.
  always_ff @(posedge Reloj) begin
    if (!Reset_n) previo_q <= 1'b0;
    else          previo_q <= Tecla;
  end

  assign Pulso = Tecla & ~previo_q;

endmodule

// File: rtl/capturador_numero_2digitos.sv
// Two-digit keypad entry capture (tens then units) producing a 6-bit value
// for the set-membership comparator. Illegal digits and values above 63 are
// rejected with an Error pulse. Borrar aborts the entry with no pulse.
//
// Optional feature: define ENTRADA_TIMEOUT_EN to abandon an entry (with an
// Error pulse) when no units digit arrives within TIMEOUT_CICLOS cycles.
//
// Handshake: Valido and Error are single-cycle pulses, mutually exclusive,
// registered one cycle after the accepting key edge; Numero is stable between
// Valido pulses and there is no back-pressure from the comparator.
module capturador_numero_2digitos
  import entrada_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic       Reloj,
  input  logic       Reset_n,
  input  logic [3:0] Digito,
  input  logic       Tecla,
  input  logic       Borrar,
  output logic [5:0] Numero,
  output logic       Valido,
  output logic       Error,
  output logic       Ocupado,
  output estado_e    Estado_dbg
);

  logic       flanco;
  estado_e    estado_q, estado_d;
  logic [2:0] decena_q, decena_d;
  logic [5:0] numero_q, numero_d;
  logic       valido_q, valido_d;
  logic       error_q, error_d;
  logic [6:0] valor;
  logic       timeout;

  detector_flanco u_flanco (
    .Reloj  (Reloj),
    .Reset_n(Reset_n),
    .Tecla  (Tecla),
    .Pulso  (flanco)
  );

  assign valor = calc_valor(decena_q, Digito);

`ifdef ENTRADA_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while waiting for the units digit; zero elsewhere so
  // it starts from 0 every time UNIDAD is entered.
  always_comb begin
    cnt_d = '0;
    if (estado_q == UNIDAD) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge Reloj) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign timeout = (estado_q == UNIDAD) && (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1));
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CICLOS;
  assign timeout = 1'b0;
`endif

  // Next state and output pulses; Borrar first, then an accepted key, then
  // the timeout (a key on the timeout cycle wins).
  always_comb begin
    estado_d = estado_q;
    decena_d = decena_q;
    numero_d = numero_q;
    valido_d = 1'b0;
    error_d  = 1'b0;
    if (Borrar) begin
      estado_d = DECENA;
    end else if (flanco) begin
      case (estado_q)
        DECENA: begin
          if (Digito <= DECENA_MAX) begin
            decena_d = Digito[2:0];
            estado_d = UNIDAD;
          end else begin
            error_d = 1'b1;
          end
        end
        UNIDAD: begin
          estado_d = DECENA;
          if ((Digito <= DIGITO_MAX) && (valor <= NUMERO_MAX)) begin
            numero_d = valor[5:0];
            valido_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: estado_d = DECENA;
      endcase
    end else if (timeout) begin
      estado_d = DECENA;
      error_d  = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Reloj) begin
    if (!Reset_n) begin
      estado_q <= DECENA;
      decena_q <= 3'd0;
      numero_q <= 6'd0;
      valido_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      decena_q <= decena_d;
      numero_q <= numero_d;
      valido_q <= valido_d;
      error_q  <= error_d;
    end
  end

  assign Numero     = numero_q;
  assign Valido     = valido_q;
  assign Error      = error_q;
  assign Ocupado    = (estado_q == UNIDAD);
  assign Estado_dbg = estado_q;

endmodule

// File: tb/tb_capturador_numero_2digitos.sv
// Directed bench for capturador_numero_2digitos. Each expected Valido/Error
// event is queued as {is_valido, numero}; a monitor pops on every pulse.
module tb_capturador_numero_2digitos;
  import entrada_pkg::*;

  localparam int W = 7;

  logic       clk;
  logic       rst_n;
  logic [3:0] digito;
  logic       tecla;
  logic       borrar;
  logic [5:0] numero;
  logic       valido;
  logic       error;
  logic       ocupado;
  estado_e    estado_dbg;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  capturador_numero_2digitos #(.TIMEOUT_CICLOS(16)) dut (
    .Reloj     (clk),
    .Reset_n   (rst_n),
    .Digito    (digito),
    .Tecla     (tecla),
    .Borrar    (borrar),
    .Numero    (numero),
    .Valido    (valido),
    .Error     (error),
    .Ocupado   (ocupado),
    .Estado_dbg(estado_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: present digit with key held for 'hold' cycles, then one low cycle
  task automatic press(input logic [3:0] d, input int hold);
    @(negedge clk);
    digito = d;
    tecla  = 1'b1;
    repeat (hold) @(negedge clk);
    tecla = 1'b0;
  endtask

  task automatic expect_ev(input logic is_valido, input logic [5:0] num);
    exp_q.push_back({is_valido, num});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && (valido || error)) begin
      chk("valido_error_exclusive", int'({valido, error} == 2'b11), 0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valido=%0b error=%0b numero=%0d expected none",
                 valido, error, numero);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("event_kind", int'(valido), int'(e[6]));
        chk("event_numero", int'(numero), int'(e[5:0]));
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    digito = 4'd0;
    tecla  = 1'b0;
    borrar = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_numero", int'(numero), 0);
    chk("rst_valido", int'(valido), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_estado", int'(estado_dbg), int'(DECENA));
    rst_n = 1'b1;
    @(negedge clk);

    // 2,5 -> 25
    press(4'd2, 3);
    @(negedge clk);
    chk("ocupado_after_tens", int'(ocupado), 1);
    expect_ev(1'b1, 6'd25);
    press(4'd5, 3);
    @(negedge clk);
    chk("numero_25", int'(numero), 25);
    chk("ocupado_after_units", int'(ocupado), 0);

    // 6,4 -> 64 out of range
    press(4'd6, 2);
    expect_ev(1'b0, 6'd25);
    press(4'd4, 2);
    @(negedge clk);
    chk("numero_kept_25", int'(numero), 25);
    chk("estado_after_64", int'(estado_dbg), int'(DECENA));

    // 5,3 -> 53
    press(4'd5, 1);
    expect_ev(1'b1, 6'd53);
    press(4'd3, 1);
    @(negedge clk);
    chk("numero_53", int'(numero), 53);

    // illegal tens digit A
    expect_ev(1'b0, 6'd53);
    press(4'hA, 2);
    @(negedge clk);
    chk("ocupado_after_A", int'(ocupado), 0);
    press(4'd0, 1);
    expect_ev(1'b1, 6'd1);
    press(4'd1, 1);
    @(negedge clk);
    chk("numero_01", int'(numero), 1);

    // illegal units digit B
    press(4'd2, 1);
    expect_ev(1'b0, 6'd1);
    press(4'hB, 1);
    @(negedge clk);
    chk("ocupado_after_B", int'(ocupado), 0);

    // tens digit 7 rejected
    expect_ev(1'b0, 6'd1);
    press(4'd7, 1);
    @(negedge clk);
    chk("ocupado_after_7", int'(ocupado), 0);

    // boundary 63 accepted
    press(4'd6, 1);
    expect_ev(1'b1, 6'd63);
    press(4'd3, 1);
    @(negedge clk);
    chk("numero_63", int'(numero), 63);

    // Borrar with same-cycle key edge
    press(4'd3, 1);
    @(negedge clk);
    chk("ocupado_before_borrar", int'(ocupado), 1);
    digito = 4'd7;
    tecla  = 1'b1;
    borrar = 1'b1;
    @(negedge clk);
    borrar = 1'b0;
    tecla  = 1'b0;
    chk("borrar_ocupado", int'(ocupado), 0);
    chk("borrar_numero", int'(numero), 63);
    @(negedge clk);

    // key held 20 cycles counts once
    press(4'd1, 20);
    @(negedge clk);
    chk("held_ocupado", int'(ocupado), 1);
    expect_ev(1'b1, 6'd19);
    press(4'd9, 1);
    @(negedge clk);
    chk("numero_19", int'(numero), 19);

    // back-to-back with minimum gaps
    press(4'd1, 1);
    expect_ev(1'b1, 6'd12);
    press(4'd2, 1);
    @(negedge clk);
    chk("numero_12", int'(numero), 12);

    // reset mid-entry
    press(4'd4, 1);
    @(negedge clk);
    chk("ocupado_before_reset", int'(ocupado), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_numero", int'(numero), 0);
    chk("midrst_ocupado", int'(ocupado), 0);
    chk("midrst_valido", int'(valido), 0);
    chk("midrst_error", int'(error), 0);
    rst_n = 1'b1;
    @(negedge clk);
    press(4'd5, 1);
    expect_ev(1'b1, 6'd50);
    press(4'd0, 1);
    @(negedge clk);
    chk("numero_50", int'(numero), 50);

    // units-digit timeout
    press(4'd4, 1);
`ifdef ENTRADA_TIMEOUT_EN
    expect_ev(1'b0, 6'd50);
    repeat (20) @(negedge clk);
    chk("timeout_ocupado", int'(ocupado), 0);
`else
    repeat (20) @(negedge clk);
    chk("no_timeout_ocupado", int'(ocupado), 1);
    borrar = 1'b1;
    @(negedge clk);
    borrar = 1'b0;
    chk("no_timeout_cleared", int'(ocupado), 0);
`endif
    chk("numero_after_timeout_case", int'(numero), 50);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
